logicnet_lut_neuron_prog: RTL

Parametrised, runtime-programmable LogicNet neuron.
- Maps an IN_BITS-wide quantised input vector to an OUT_BITS-wide quantised activation through a 2**IN_BITS-entry distributed-RAM truth table.
- The table is written over a configuration port.
- Lookups stream through a two-stage valid/ready pipeline.
- Sits inside a generated layer in place of fixed per-neuron ROMs, so one bitstream can host retrained networks.

---
 rtl/logicnet_lut_neuron_prog.sv | 111 +++++++++++
 1 files changed

// File: rtl/logicnet_lut_neuron_prog.sv
// Runtime-programmable LogicNet neuron: 2**IN_BITS-entry truth table behind a two-stage valid/ready pipeline.
// Optional table readback port enabled by defining LOGICNET_LUT_READBACK_EN.
module logicnet_lut_neuron_prog #(
  parameter int                  IN_BITS     = 6,
  parameter int                  OUT_BITS    = 2,
  parameter logic [OUT_BITS-1:0] DEFAULT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [IN_BITS-1:0]  cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_busy,
`ifdef LOGICNET_LUT_READBACK_EN
  input  logic                cfg_re,
  output logic [OUT_BITS-1:0] cfg_rdata,
  output logic                cfg_rvalid,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int DEPTH = 2**IN_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t               state_q, state_d;
  logic [IN_BITS-1:0]   ptr_q;
  logic [OUT_BITS-1:0]  table_mem [DEPTH];

  logic                 vld_p1;
  logic [OUT_BITS-1:0]  d_p1;
  logic                 advance;
  logic                 accept;
  logic                 run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) ptr_q <= ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (ptr_q == '1) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign run      = (state_q == RUN);
  assign cfg_busy = (state_q == INIT);
  assign advance  = !out_valid || out_ready;
  assign in_ready = run && (!vld_p1 || advance);
  assign accept   = in_valid && in_ready;

  // Table writes: the init sweep owns the port until RUN; reads below see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (state_q == INIT) table_mem[ptr_q] <= DEFAULT_VAL;
    else if (cfg_we)     table_mem[cfg_addr] <= cfg_data;
  end

  // Stage p1: synchronous table read on accept
  always_ff @(posedge clk) begin
    if (accept) d_p1 <= table_mem[in_data];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (advance) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage p2: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= vld_p1;
      if (vld_p1) out_data <= d_p1;
    end
  end

`ifdef LOGICNET_LUT_READBACK_EN
  // Readback: independent read port, never interacts with the lookup handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      cfg_rvalid <= run && cfg_re;
      if (run && cfg_re) cfg_rdata <= table_mem[cfg_addr];
    end
  end
`endif

endmodule
